// File: rtl/kbd_report_decoder.sv
// rtl/kbd_report_decoder.sv - assembles 8-byte HID boot-keyboard reports and emits newly pressed keycodes
module kbd_report_decoder #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_valid_i,
    input  logic       rx_sof_i,
    input  logic [7:0] rx_data_i,
    output logic [7:0] kbd_status_o,
    output logic [7:0] kbd_data_o,
    output logic       kbd_strobe_o,
    output logic       busy_o,
    output logic       overrun_o
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_EMIT, S_GAP} state_e;

    localparam logic [7:0] HOLD_M1 = 8'(HOLD_CYCLES - 1);

    state_e          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0][7:0] rxbuf_q, rxbuf_d;
    logic [5:0][7:0] newbuf_q, newbuf_d;
    logic [5:0][7:0] prev_q, prev_d;
    logic            pending_q, pending_d;
    logic [2:0]      slot_q, slot_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      status_q, status_d;
    logic [7:0]      data_q, data_d;
    logic            strobe_q, strobe_d;
    logic            overrun_q, overrun_d;

    logic            rollover;
    logic            seen;
    logic            emit_ok;
    logic [7:0]      cur_key;

    // A report containing ErrorRollOver in any key slot carries no usable key state.
    always_comb begin
        rollover = 1'b0;
        for (int i = 2; i < 8; i++) begin
            if (rxbuf_q[i] == 8'h01) rollover = 1'b1;
        end
    end

    always_comb begin
        cur_key = newbuf_q[slot_q];
        seen    = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (prev_q[j] == cur_key) seen = 1'b1;
        end
        emit_ok = (cur_key >= 8'h04) && !seen;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rxbuf_d   = rxbuf_q;
        newbuf_d  = newbuf_q;
        prev_d    = prev_q;
        pending_d = pending_q;
        slot_d    = slot_q;
        cnt_d     = cnt_q;
        status_d  = status_q;
        data_d    = data_q;
        strobe_d  = 1'b0;
        overrun_d = 1'b0;

        // A completed report is frozen in rxbuf until the FSM takes it.
        if (rx_valid_i) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else if (rx_sof_i) begin
                rxbuf_d[0] = rx_data_i;
                idx_d      = 3'd1;
            end else begin
                rxbuf_d[idx_q] = rx_data_i;
                idx_d          = idx_q + 3'd1;
                if (idx_q == 3'd7) pending_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    if (!rollover) begin
                        newbuf_d = rxbuf_q[7:2];
                        status_d = rxbuf_q[0];
                        slot_d   = 3'd0;
                        state_d  = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (emit_ok) begin
                    data_d   = cur_key;
                    strobe_d = 1'b1;
                    cnt_d    = HOLD_M1;
                    state_d  = S_EMIT;
                end else if (slot_q == 3'd5) begin
                    prev_d  = newbuf_q;
                    state_d = S_IDLE;
                end else begin
                    slot_d = slot_q + 3'd1;
                end
            end
            S_EMIT: begin
                if (cnt_q == 8'd0) begin
                    data_d  = 8'h00;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_GAP: begin
                if (slot_q == 3'd5) begin
                    prev_d  = newbuf_q;
                    state_d = S_IDLE;
                end else begin
                    slot_d  = slot_q + 3'd1;
                    state_d = S_CHECK;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            idx_q     <= 3'd0;
            rxbuf_q   <= '0;
            newbuf_q  <= '0;
            prev_q    <= '0;
            pending_q <= 1'b0;
            slot_q    <= 3'd0;
            cnt_q     <= 8'd0;
            status_q  <= 8'h00;
            data_q    <= 8'h00;
            strobe_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rxbuf_q   <= rxbuf_d;
            newbuf_q  <= newbuf_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
            slot_q    <= slot_d;
            cnt_q     <= cnt_d;
            status_q  <= status_d;
            data_q    <= data_d;
            strobe_q  <= strobe_d;
            overrun_q <= overrun_d;
        end
    end

    assign kbd_status_o = status_q;
    assign kbd_data_o   = data_q;
    assign kbd_strobe_o = strobe_q;
    assign overrun_o    = overrun_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule
